// File: rtl/pe_feeder_pkg.sv
// Shared types and constants for the PE stream feeder and its skid FIFO.
package pe_feeder_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LSTART = 2'd1,
      ST_STREAM = 2'd2,
      ST_DONE   = 2'd3
   } feeder_state_e;

   localparam int SKID_DEPTH      = 2;
   localparam int SKID_CNT_WIDTH  = 2;
   localparam int STALL_CNT_WIDTH = 16;

endpackage

// File: rtl/pe_skid_fifo.sv
// Two-entry skid FIFO that absorbs the one-cycle buffer read latency.
module pe_skid_fifo
   import pe_feeder_pkg::*;
#(
   parameter int DATA_WIDTH = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      push,
   input  logic                      pop,
   input  logic [DATA_WIDTH-1:0]     wr_data,
   output logic [DATA_WIDTH-1:0]     rd_data,
   output logic                      full,
   output logic                      empty,
   output logic [SKID_CNT_WIDTH-1:0] count
);

   logic [DATA_WIDTH-1:0] mem [SKID_DEPTH];
   logic                  wr_ptr;
   logic                  rd_ptr;

   // With two entries a single toggling bit is a complete pointer.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= '0;
         for (int i = 0; i < SKID_DEPTH; i++) mem[i] <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= wr_data;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         case ({push, pop})
            2'b10:   count <= count + SKID_CNT_WIDTH'(1);
            2'b01:   count <= count - SKID_CNT_WIDTH'(1);
            default: count <= count;
         endcase
      end
   end

   assign rd_data = mem[rd_ptr];
   assign full    = (count == SKID_CNT_WIDTH'(SKID_DEPTH));
   assign empty   = (count == '0);

endmodule

// File: rtl/pe_stream_feeder.sv
// Streams a block of buffer words into one PE input port behind a load-start pulse.
// Optional stall counter port enabled by PE_STREAM_FEEDER_STALL_CNT_EN.
//
// state  | meaning
// IDLE   | waiting for start
// LSTART | pe_load_start pulse, first buffer read issued
// STREAM | reading buffer, forwarding words as PE FIFO allows
// DONE   | one-cycle done pulse
module pe_stream_feeder
   import pe_feeder_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 8,
   parameter int LEN_WIDTH  = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic [ADDR_WIDTH-1:0]      base_addr,
   input  logic [LEN_WIDTH-1:0]       length,
   output logic                       busy,
   output logic                       done,
   output logic                       buf_rd_en,
   output logic [ADDR_WIDTH-1:0]      buf_rd_addr,
   input  logic [DATA_WIDTH-1:0]      buf_rd_data,
   output logic                       pe_load_start,
   output logic [DATA_WIDTH-1:0]      pe_data,
   output logic                       pe_data_en,
`ifdef PE_STREAM_FEEDER_STALL_CNT_EN
   output logic [STALL_CNT_WIDTH-1:0] stall_cnt,
`endif
   input  logic                       pe_fifo_full
);

   feeder_state_e             state;
   logic [LEN_WIDTH-1:0]      len_q;
   logic [LEN_WIDTH-1:0]      reads_issued;
   logic [LEN_WIDTH-1:0]      words_sent;
   logic                      rd_inflight;
   logic                      skid_full;
   logic                      skid_empty;
   logic [SKID_CNT_WIDTH-1:0] skid_count;
   logic [2:0]                occ_after_pop;
   logic                      reading;

   pe_skid_fifo #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
      .clk     (clk),
      .rst     (rst),
      .push    (rd_inflight),
      .pop     (pe_data_en),
      .wr_data (buf_rd_data),
      .rd_data (pe_data),
      .full    (skid_full),
      .empty   (skid_empty),
      .count   (skid_count)
   );

   assign pe_data_en = !skid_empty && !pe_fifo_full;

   // Credit the word leaving this cycle so a steady stream runs at one word per cycle.
   assign occ_after_pop = {1'b0, skid_count} + {2'b00, rd_inflight} - {2'b00, pe_data_en};
   assign reading       = (state == ST_LSTART) || (state == ST_STREAM);
   assign buf_rd_en     = reading && (reads_issued < len_q)
                          && !(skid_full && !pe_data_en) && (occ_after_pop < 3'd2);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= ST_IDLE;
         len_q         <= '0;
         reads_issued  <= '0;
         words_sent    <= '0;
         rd_inflight   <= 1'b0;
         buf_rd_addr   <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         pe_load_start <= 1'b0;
      end else begin
         pe_load_start <= 1'b0;
         done          <= 1'b0;
         rd_inflight   <= buf_rd_en;
         if (buf_rd_en) begin
            buf_rd_addr  <= buf_rd_addr + ADDR_WIDTH'(1);
            reads_issued <= reads_issued + LEN_WIDTH'(1);
         end
         if (pe_data_en) words_sent <= words_sent + LEN_WIDTH'(1);
         case (state)
            ST_IDLE: begin
               if (start) begin
                  if (length != '0) begin
                     state         <= ST_LSTART;
                     buf_rd_addr   <= base_addr;
                     len_q         <= length;
                     reads_issued  <= '0;
                     words_sent    <= '0;
                     busy          <= 1'b1;
                     pe_load_start <= 1'b1;
                  end else begin
                     state <= ST_DONE;
                     done  <= 1'b1;
                  end
               end
            end
            ST_LSTART: state <= ST_STREAM;
            ST_STREAM: begin
               if (pe_data_en && (words_sent + LEN_WIDTH'(1) == len_q)) begin
                  state <= ST_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

`ifdef PE_STREAM_FEEDER_STALL_CNT_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt <= '0;
      end else if ((state == ST_IDLE) && start) begin
         stall_cnt <= '0;
      end else if ((state == ST_STREAM) && !skid_empty && pe_fifo_full && (stall_cnt != '1)) begin
         stall_cnt <= stall_cnt + STALL_CNT_WIDTH'(1);
      end
   end
`endif

endmodule

// File: tb/tb_pe_stream_feeder.sv
// Directed bench for pe_stream_feeder with a one-cycle-latency buffer model.
module tb_pe_stream_feeder;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [7:0]  base_addr;
   logic [7:0]  length;
   logic        busy;
   logic        done;
   logic        buf_rd_en;
   logic [7:0]  buf_rd_addr;
   logic [15:0] buf_rd_data;
   logic        pe_load_start;
   logic [15:0] pe_data;
   logic        pe_data_en;
   logic        pe_fifo_full;
`ifdef PE_STREAM_FEEDER_STALL_CNT_EN
   logic [15:0] stall_cnt;
`endif

   pe_stream_feeder #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .LEN_WIDTH(8)) dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .base_addr     (base_addr),
      .length        (length),
      .busy          (busy),
      .done          (done),
      .buf_rd_en     (buf_rd_en),
      .buf_rd_addr   (buf_rd_addr),
      .buf_rd_data   (buf_rd_data),
      .pe_load_start (pe_load_start),
      .pe_data       (pe_data),
      .pe_data_en    (pe_data_en),
`ifdef PE_STREAM_FEEDER_STALL_CNT_EN
      .stall_cnt     (stall_cnt),
`endif
      .pe_fifo_full  (pe_fifo_full)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // buffer[addr] = addr + 1, one cycle read latency
   always @(posedge clk) if (buf_rd_en) buf_rd_data <= {8'h00, buf_rd_addr} + 16'd1;

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   int          load_cnt, load_cyc, rd_cnt, en_cnt, done_cnt, done_cyc;
   int          full_viol, max_outst, rd_total, acc_total;
   logic        busy_at_load, busy_at_done;
   logic [15:0] stall_at_done, stall_at_load;
   logic [15:0] data_q[$];
   int          cyc_q[$];
   logic [7:0]  addr_q[$];

   task automatic clear_mon();
      load_cnt = 0; load_cyc = -1; rd_cnt = 0; en_cnt = 0; done_cnt = 0; done_cyc = -1;
      full_viol = 0; max_outst = 0; rd_total = 0; acc_total = 0;
      busy_at_load = 1'b0; busy_at_done = 1'b1;
      stall_at_done = 16'hdead; stall_at_load = 16'hdead;
      data_q.delete(); cyc_q.delete(); addr_q.delete();
   endtask

   always @(negedge clk) if (rst) begin
      if (pe_load_start) begin
         load_cnt++; load_cyc = cyc; busy_at_load = busy;
`ifdef PE_STREAM_FEEDER_STALL_CNT_EN
         stall_at_load = stall_cnt;
`endif
      end
      if (buf_rd_en) begin rd_cnt++; addr_q.push_back(buf_rd_addr); end
      if (pe_data_en) begin
         en_cnt++; data_q.push_back(pe_data); cyc_q.push_back(cyc);
         if (pe_fifo_full) full_viol++;
      end
      if (rd_total - acc_total > max_outst) max_outst = rd_total - acc_total;
      rd_total  += int'(buf_rd_en);
      acc_total += int'(pe_data_en);
      if (done) begin
         done_cnt++; done_cyc = cyc; busy_at_done = busy;
`ifdef PE_STREAM_FEEDER_STALL_CNT_EN
         stall_at_done = stall_cnt;
`endif
      end
   end

   int sc = 0;
   int full_mode = 0;

   function automatic logic full_fn(input int mode, input int k);
      case (mode)
         1:       return ((k >= 2) && (k <= 5)) || ((k > 5) && (k % 2 == 1));
         2:       return (k >= 3) && (k <= 8);
         default: return 1'b0;
      endcase
   endfunction

   task automatic do_start(input logic [7:0] b, input logic [7:0] l);
      @(posedge clk); #1;
      start = 1'b1; base_addr = b; length = l; sc = cyc;
      @(posedge clk); #1;
      start = 1'b0;
      pe_fifo_full = full_fn(full_mode, cyc - sc);
   endtask

   task automatic wait_done(input int bound);
      int n = 0;
      while (done_cnt == 0 && n < bound) begin
         @(posedge clk); #1;
         pe_fifo_full = full_fn(full_mode, cyc - sc);
         n++;
      end
      if (done_cnt == 0) chk("done_timeout", 32'd0, 32'd1);
      pe_fifo_full = 1'b0;
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk({tag, "_busy"},  {31'd0, busy},          32'd0);
      chk({tag, "_done"},  {31'd0, done},          32'd0);
      chk({tag, "_rd_en"}, {31'd0, buf_rd_en},     32'd0);
      chk({tag, "_addr"},  {24'd0, buf_rd_addr},   32'd0);
      chk({tag, "_lstrt"}, {31'd0, pe_load_start}, 32'd0);
      chk({tag, "_den"},   {31'd0, pe_data_en},    32'd0);
      chk({tag, "_data"},  {16'd0, pe_data},       32'd0);
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; base_addr = 8'd0; length = 8'd0; pe_fifo_full = 1'b0;
      clear_mon();
      #3;
      chk_outputs_zero("reset");
      @(posedge clk); #1; @(posedge clk); #1;
      rst = 1'b1;

      // 12 words, no backpressure: latency and throughput
      clear_mon(); full_mode = 0;
      do_start(8'd0, 8'd12);
      wait_done(60);
      chk("t1_load_cnt", load_cnt, 1);
      chk("t1_load_cyc", load_cyc, sc + 1);
      chk("t1_busy_at_load", {31'd0, busy_at_load}, 32'd1);
      chk("t1_words", data_q.size(), 12);
      for (int i = 0; i < 12 && i < data_q.size(); i++) begin
         chk($sformatf("t1_data%0d", i), {16'd0, data_q[i]}, i + 1);
         chk($sformatf("t1_cyc%0d", i), cyc_q[i], sc + 3 + i);
      end
      chk("t1_done_cyc", done_cyc, sc + 15);
      chk("t1_busy_at_done", {31'd0, busy_at_done}, 32'd0);

      // backpressure, base 10, length 9
      clear_mon(); full_mode = 1;
      do_start(8'd10, 8'd9);
      wait_done(100);
      chk("t2_words", data_q.size(), 9);
      for (int i = 0; i < 9 && i < data_q.size(); i++)
         chk($sformatf("t2_data%0d", i), {16'd0, data_q[i]}, 11 + i);
      chk("t2_full_viol", full_viol, 0);
      chk("t2_outst_le2", (max_outst <= 2) ? 32'd1 : 32'd0, 32'd1);
      chk("t2_rd_cnt", rd_cnt, 9);

      // address wrap
      clear_mon(); full_mode = 0;
      do_start(8'd254, 8'd4);
      wait_done(60);
      chk("t3_rd_cnt", addr_q.size(), 4);
      chk("t3_words", data_q.size(), 4);
      if (addr_q.size() == 4 && data_q.size() == 4) begin
         chk("t3_addr0", {24'd0, addr_q[0]}, 254);
         chk("t3_addr1", {24'd0, addr_q[1]}, 255);
         chk("t3_addr2", {24'd0, addr_q[2]}, 0);
         chk("t3_addr3", {24'd0, addr_q[3]}, 1);
         chk("t3_data0", {16'd0, data_q[0]}, 255);
         chk("t3_data1", {16'd0, data_q[1]}, 256);
         chk("t3_data2", {16'd0, data_q[2]}, 1);
         chk("t3_data3", {16'd0, data_q[3]}, 2);
      end

      // zero-length start
      clear_mon(); full_mode = 0;
      do_start(8'd5, 8'd0);
      wait_done(20);
      repeat (3) @(posedge clk); #1;
      chk("t4_done_cyc", done_cyc, sc + 1);
      chk("t4_done_cnt", done_cnt, 1);
      chk("t4_load_cnt", load_cnt, 0);
      chk("t4_rd_cnt", rd_cnt, 0);
      chk("t4_en_cnt", en_cnt, 0);
      chk("t4_busy_at_done", {31'd0, busy_at_done}, 32'd0);

      // reset mid-stream after word 7, then a clean 3-word transfer
      clear_mon(); full_mode = 0;
      do_start(8'd0, 8'd20);
      begin
         int n = 0;
         while (data_q.size() < 7 && n < 100) begin @(posedge clk); #1; n++; end
      end
      chk("t5_seen7", (data_q.size() >= 7) ? 32'd1 : 32'd0, 32'd1);
      rst = 1'b0;
      #1;
      chk_outputs_zero("t5_rst");
      @(posedge clk); #1; @(posedge clk); #1;
      rst = 1'b1;
      clear_mon();
      do_start(8'd0, 8'd3);
      wait_done(40);
      repeat (4) @(posedge clk); #1;
      chk("t5_words", data_q.size(), 3);
      for (int i = 0; i < 3 && i < data_q.size(); i++)
         chk($sformatf("t5_data%0d", i), {16'd0, data_q[i]}, i + 1);

`ifdef PE_STREAM_FEEDER_STALL_CNT_EN
      clear_mon(); full_mode = 2;
      do_start(8'd0, 8'd4);
      wait_done(60);
      chk("t6_stall_at_done", {16'd0, stall_at_done}, 6);
      repeat (2) @(posedge clk); #1;
      chk("t6_stall_hold", {16'd0, stall_cnt}, 6);
      clear_mon(); full_mode = 0;
      do_start(8'd0, 8'd1);
      wait_done(20);
      chk("t6_stall_cleared", {16'd0, stall_at_load}, 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
